lcd_panel_emulator: RTL and testbench
=====================================

# lcd_panel_emulator

Synthesizable model of the panel side of the two-chip graphic LCD bus (page/column display RAM, E-strobed writes). It sits opposite the LCD writer FSMs. It decodes their instruction and data writes into a 2×8×64-byte display RAM and answers status and data reads. A separate read port exposes the RAM to the VGA mirror and to the test benches.

## Interface
- BUSY_CYCLES, default 4: CLK cycles that BUSY stays set after each accepted transaction (≥1).
- CLK  in  1  system clock, ≥4× the LCD_ENABLE strobe rate.
- RESET  in  1  asynchronous, active-high; clears all control state.
- LCD_ENABLE  in  1  bus strobe; a transaction commits on its falling edge.
- LCD_RW, LCD_DI  in  1 each  0/0 instruction write, 1/0 data write, 0/1 status read, 1/1 data read.
- LCD_CS1, LCD_CS2  in  1 each  active-high chip selects; CS1 selects chip 0 and CS2 selects chip 1.
- LCD_RSTN  in  1  active-low panel reset.
- LCD_DATA_IN  in  8  bus data from the host.
- LCD_DATA_OUT  out  8  read data; LCD_DATA_OE  out  1  bus drive enable.
- RD_CHIP  in  1; RD_PAGE  in  3; RD_COL  in  6: mirror read address.
- RD_DATA  out  8  mirror read data.
- DISPLAY_ON  out  2  display on flag per chip; START_LINE0, START_LINE1  out  6 each.
- BUSY  out  2  per-chip busy; ERR_OVERRUN  out  1  sticky, set when a transaction is dropped.

## Operation
- Every bus input passes through a 2-FF synchronizer. Bus values are captured on each cycle that the synchronized ENABLE is high.
- A commit happens on the synchronized falling edge of ENABLE, using the last captured values. The commit applies to each selected chip independently.
- A commit with no chip selected is ignored.
- Instruction decode (DI=0, RW=0):
  - 0011111x sets ON := x.
  - 11ssssss sets START_LINE := s.
  - 10111ppp sets PAGE := p.
  - 01yyyyyy sets Y := y.
  - Any other code is ignored but still sets BUSY.
- Data write (DI=1, RW=0): RAM[chip][PAGE][Y] := data, then Y := (Y+1) mod 64. PAGE never auto-increments. With both chips selected, both chips are written (broadcast).
- Status read (DI=0, RW=1): LCD_DATA_OUT = {BUSY, 1'b0, ~ON, RSTN_LOW, 4'b0} of the selected chip. It is combinational from the synchronized signals. The commit has no state effect.
- Data read (DI=1, RW=1):
  - LCD_DATA_OUT shows the chip's output latch.
  - At the commit, latch := RAM[chip][PAGE][Y] and Y := Y+1 mod 64.
  - The first read after a Y or PAGE change therefore returns the stale latch (dummy read).
- A read requires exactly one chip selected. Otherwise LCD_DATA_OUT = 0x00, LCD_DATA_OE = 0, and the commit has no state change.
- LCD_DATA_OE = synced ENABLE & synced RW & exactly one chip selected.
- Busy and overrun: each accepted commit on a chip loads that chip's counter with BUSY_CYCLES. A commit that arrives while the chip's BUSY is set is dropped for that chip and sets ERR_OVERRUN. Status reads are always accepted and never set BUSY.
- Panel reset: while the synchronized LCD_RSTN is low, ON, START_LINE, PAGE, Y, the latch and BUSY are held at 0. All write and data-read commits are dropped without setting ERR_OVERRUN. The status reset bit reads 1.
- RAM: one write port, one internal read port and the mirror port. RAM is not cleared by either reset.

## Timing
- RESET value of every output and register: 0. This covers LCD_DATA_OUT, LCD_DATA_OE, RD_DATA, DISPLAY_ON, START_LINEx, BUSY and ERR_OVERRUN, plus PAGE, Y, the latches and the counters.
- A commit takes effect 3 CLK cycles after LCD_ENABLE falls: 2 synchronizer stages plus 1 edge-detect cycle. Register outputs update on that edge.
- BUSY is high for exactly BUSY_CYCLES cycles, starting the cycle after the commit.
- RD_DATA has 1-cycle registered latency. A write and a mirror read to the same address in the same cycle return the old data.
- RESET asserted mid-transaction aborts the transaction; no commit occurs, even if ENABLE falls later, until a new rising edge of ENABLE is seen.

## Configuration
- LCD_READBACK_EN defined: status and data reads, the output latches, LCD_DATA_OUT and LCD_DATA_OE are implemented as described above.
- LCD_READBACK_EN undefined: RW=1 commits are ignored and do not set BUSY. LCD_DATA_OUT is tied to 0x00 and LCD_DATA_OE to 0. The latch logic and the internal read port are removed. The mirror port remains.

## Test plan
- Instruction writes on CS1 only, 0x3F then 0xC5 → DISPLAY_ON=2'b01, START_LINE0=5, chip 1 unchanged.
- 0xBB, 0x40, then data 0xAA, 0x55 on CS2 → RAM[1][3][0]=0xAA, RAM[1][3][1]=0x55; the mirror read shows them 1 cycle after the address is applied.
- Y set to 63, then two data writes → the second write lands in column 0 of the same page.
- Two commits spaced less than BUSY_CYCLES apart → the second is dropped, ERR_OVERRUN=1, RAM unchanged.
- With LCD_READBACK_EN: 0x40, then two data reads of a column holding 0x3C → first returns the stale latch (0x00 after reset), second returns 0x3C; Y has advanced by 2.
- LCD_RSTN low during writes, then RESET pulsed mid-strobe → status bit4=1, writes dropped; all outputs 0 after RESET; RAM contents retained.

Source files
------------

// File: rtl/lcd_panel_emulator.sv
// ---------------------------------------------------------------------------
// lcd_panel_emulator
//   Panel side of the two-chip graphic LCD bus. Every bus input is brought
//   into the CLK domain through a 2-FF synchronizer. A transaction commits on
//   the synchronized falling edge of LCD_ENABLE and is applied to each selected
//   chip. Each chip holds 8 pages x 64 columns of display RAM.
//
//   Optional feature macro: LCD_READBACK_EN
//     defined   : status/data reads, per-chip output latches, LCD_DATA_OUT/OE
//     undefined : RW=1 commits ignored, LCD_DATA_OUT=0, LCD_DATA_OE=0
//
//   Ports
//     CLK, RESET (async, active-high)
//     LCD_ENABLE, LCD_RW, LCD_DI, LCD_CS1, LCD_CS2, LCD_RSTN, LCD_DATA_IN : host bus
//     LCD_DATA_OUT, LCD_DATA_OE     : read data / bus drive enable
//     RD_CHIP, RD_PAGE, RD_COL      : mirror read address
//     RD_DATA                       : mirror read data, 1-cycle latency
//     DISPLAY_ON, START_LINE0/1     : per-chip display state
//     BUSY, ERR_OVERRUN             : per-chip busy, sticky dropped-commit flag
// ---------------------------------------------------------------------------

// Per-chip controller: instruction decode, page/column pointers, busy counter,
// display RAM with a write port, an internal read port and the mirror port.
module lcd_chip #(
    parameter int BUSY_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       commit,    // commit addressed to this chip
    input  logic       op_ok,     // transaction type takes effect on a chip
    input  logic       rstn_low,  // synchronized panel reset asserted
    input  logic       rw,
    input  logic       di,
    input  logic [7:0] data,
    input  logic [2:0] rd_page,
    input  logic [5:0] rd_col,
    output logic       on,
    output logic [5:0] start_line,
    output logic       busy,
    output logic       overrun,   // pulse: commit dropped because busy
`ifdef LCD_READBACK_EN
    output logic [7:0] latch,
`endif
    output logic [7:0] mir_data
);
    localparam int CW = $clog2(BUSY_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [2:0]    page;
    logic [5:0]    y;
    logic [7:0]    mem [0:511];
    logic          accept;

    assign busy    = (cnt != '0);
    // Panel reset swallows commits silently; only a busy chip flags overrun.
    assign accept  = commit & op_ok & ~rstn_low & ~busy;
    assign overrun = commit & op_ok & ~rstn_low &  busy;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            on         <= 1'b0;
            start_line <= '0;
            page       <= '0;
            y          <= '0;
            cnt        <= '0;
`ifdef LCD_READBACK_EN
            latch      <= '0;
`endif
        end else if (rstn_low) begin
            on         <= 1'b0;
            start_line <= '0;
            page       <= '0;
            y          <= '0;
            cnt        <= '0;
`ifdef LCD_READBACK_EN
            latch      <= '0;
`endif
        end else if (accept) begin
            cnt <= CW'(BUSY_CYCLES);
            if (!rw && !di) begin
                casez (data)
                    8'b0011111?: on         <= data[0];
                    8'b11??????: start_line <= data[5:0];
                    8'b10111???: page       <= data[2:0];
                    8'b01??????: y          <= data[5:0];
                    default: ;  // unknown codes only set busy
                endcase
            end else begin
                // data write or data read: column steps, page never does
                y <= y + 6'd1;
`ifdef LCD_READBACK_EN
                if (rw) latch <= mem[{page, y}];
`endif
            end
        end else if (busy) begin
            cnt <= cnt - CW'(1);
        end
    end

    // RAM is deliberately outside any reset.
    always_ff @(posedge CLK) begin
        if (accept && !rw && di) mem[{page, y}] <= data;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) mir_data <= '0;
        else       mir_data <= mem[{rd_page, rd_col}];
    end
endmodule

module lcd_panel_emulator #(
    parameter int BUSY_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_ENABLE,
    input  logic       LCD_RW,
    input  logic       LCD_DI,
    input  logic       LCD_CS1,
    input  logic       LCD_CS2,
    input  logic       LCD_RSTN,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] LCD_DATA_OUT,
    output logic       LCD_DATA_OE,
    input  logic       RD_CHIP,
    input  logic [2:0] RD_PAGE,
    input  logic [5:0] RD_COL,
    output logic [7:0] RD_DATA,
    output logic [1:0] DISPLAY_ON,
    output logic [5:0] START_LINE0,
    output logic [5:0] START_LINE1,
    output logic [1:0] BUSY,
    output logic       ERR_OVERRUN
);
    typedef struct packed {
        logic       en;
        logic       rw;
        logic       di;
        logic [1:0] cs;    // cs[0]=CS1 -> chip 0, cs[1]=CS2 -> chip 1
        logic       rstn;
        logic [7:0] data;
    } lcd_bus_t;

    lcd_bus_t   bus_in, sync1, sync2;
    logic       en_d, armed, commit, rstn_low, op_ok, rd_chip_q;
    logic [2:0] vld_pipe;
    logic       cap_rw, cap_di;
    logic [1:0] cap_cs;
    logic [7:0] cap_data;

    logic [1:0]       on_v, busy_v, ovr_v;
    logic [1:0][5:0]  sl_v;
    logic [1:0][7:0]  mir_v;
`ifdef LCD_READBACK_EN
    logic [1:0][7:0]  lat_v;
`endif

    assign bus_in = {LCD_ENABLE, LCD_RW, LCD_DI, LCD_CS2, LCD_CS1, LCD_RSTN, LCD_DATA_IN};

    // vld_pipe fills with ones after RESET; once vld_pipe[2] is set both the
    // synchronized enable and its delayed copy are genuine samples, so a strobe
    // that straddled RESET cannot fake a rising edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1    <= '0;
            sync2    <= '0;
            en_d     <= 1'b0;
            armed    <= 1'b0;
            vld_pipe <= '0;
            cap_rw   <= 1'b0;
            cap_di   <= 1'b0;
            cap_cs   <= '0;
            cap_data <= '0;
        end else begin
            sync1    <= bus_in;
            sync2    <= sync1;
            en_d     <= sync2.en;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
            if (sync2.en) begin
                cap_rw   <= sync2.rw;
                cap_di   <= sync2.di;
                cap_cs   <= sync2.cs;
                cap_data <= sync2.data;
            end
            if (commit)                                     armed <= 1'b0;
            else if (vld_pipe[2] && sync2.en && !en_d)      armed <= 1'b1;
        end
    end

    assign commit   = armed & en_d & ~sync2.en;
    assign rstn_low = ~sync2.rstn;

`ifdef LCD_READBACK_EN
    // data reads act only with exactly one chip selected; status reads never act
    assign op_ok = ~cap_rw | (cap_di & (cap_cs[0] ^ cap_cs[1]));
`else
    assign op_ok = ~cap_rw;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_chip
        lcd_chip #(.BUSY_CYCLES(BUSY_CYCLES)) u_chip (
            .CLK        (CLK),
            .RESET      (RESET),
            .commit     (commit & cap_cs[c]),
            .op_ok      (op_ok),
            .rstn_low   (rstn_low),
            .rw         (cap_rw),
            .di         (cap_di),
            .data       (cap_data),
            .rd_page    (RD_PAGE),
            .rd_col     (RD_COL),
            .on         (on_v[c]),
            .start_line (sl_v[c]),
            .busy       (busy_v[c]),
            .overrun    (ovr_v[c]),
`ifdef LCD_READBACK_EN
            .latch      (lat_v[c]),
`endif
            .mir_data   (mir_v[c])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ERR_OVERRUN <= 1'b0;
            rd_chip_q   <= 1'b0;
        end else begin
            if (|ovr_v) ERR_OVERRUN <= 1'b1;
            rd_chip_q <= RD_CHIP;
        end
    end

    assign RD_DATA     = mir_v[rd_chip_q];
    assign DISPLAY_ON  = on_v;
    assign START_LINE0 = sl_v[0];
    assign START_LINE1 = sl_v[1];
    assign BUSY        = busy_v;

`ifdef LCD_READBACK_EN
    logic       sel_s;
    logic [7:0] status_s;

    assign sel_s       = sync2.cs[1];
    assign LCD_DATA_OE = sync2.en & sync2.rw & (sync2.cs[0] ^ sync2.cs[1]);
    assign status_s    = {busy_v[sel_s], 1'b0, ~on_v[sel_s], rstn_low, 4'b0000};

    always_comb begin
        LCD_DATA_OUT = 8'h00;
        if (LCD_DATA_OE) LCD_DATA_OUT = sync2.di ? lat_v[sel_s] : status_s;
    end
`else
    assign LCD_DATA_OUT = 8'h00;
    assign LCD_DATA_OE  = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_panel_emulator.sv
// ---------------------------------------------------------------------------
// tb_lcd_panel_emulator
//   Directed steps followed by a randomized bus sequence. A reference model
//   holds the panel state as plain arrays and integers and applies each
//   transaction at its commit cycle (3 clocks after the ENABLE fall).
// ---------------------------------------------------------------------------
module tb_lcd_panel_emulator;
    localparam int BC = 4;
`ifdef LCD_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       CLK = 1'b0, RESET = 1'b1;
    logic       LCD_ENABLE = 1'b0, LCD_RW = 1'b0, LCD_DI = 1'b0;
    logic       LCD_CS1 = 1'b0, LCD_CS2 = 1'b0, LCD_RSTN = 1'b1;
    logic [7:0] LCD_DATA_IN = 8'h00;
    logic [7:0] LCD_DATA_OUT;
    logic       LCD_DATA_OE;
    logic       RD_CHIP = 1'b0;
    logic [2:0] RD_PAGE = 3'd0;
    logic [5:0] RD_COL = 6'd0;
    logic [7:0] RD_DATA;
    logic [1:0] DISPLAY_ON, BUSY;
    logic [5:0] START_LINE0, START_LINE1;
    logic       ERR_OVERRUN;

    lcd_panel_emulator #(.BUSY_CYCLES(BC)) dut (
        .CLK(CLK), .RESET(RESET), .LCD_ENABLE(LCD_ENABLE), .LCD_RW(LCD_RW),
        .LCD_DI(LCD_DI), .LCD_CS1(LCD_CS1), .LCD_CS2(LCD_CS2), .LCD_RSTN(LCD_RSTN),
        .LCD_DATA_IN(LCD_DATA_IN), .LCD_DATA_OUT(LCD_DATA_OUT), .LCD_DATA_OE(LCD_DATA_OE),
        .RD_CHIP(RD_CHIP), .RD_PAGE(RD_PAGE), .RD_COL(RD_COL), .RD_DATA(RD_DATA),
        .DISPLAY_ON(DISPLAY_ON), .START_LINE0(START_LINE0), .START_LINE1(START_LINE1),
        .BUSY(BUSY), .ERR_OVERRUN(ERR_OVERRUN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    // ---------------- reference model ----------------
    bit [7:0] m_mem   [2][8][64];
    bit       m_known [2][8][64];
    bit       m_on    [2];
    int       m_start [2], m_page [2], m_y [2], m_last [2];
    bit [7:0] m_lat   [2];
    bit       m_err, m_rstn_low;

    task automatic model_panel_clear();
        for (int c = 0; c < 2; c++) begin
            m_on[c] = 0; m_start[c] = 0; m_page[c] = 0; m_y[c] = 0;
            m_lat[c] = 8'h00; m_last[c] = -1000;
        end
    endtask

    task automatic model_reset();
        model_panel_clear();
        m_err = 0;
    endtask

    // k = clock count at which the commit takes effect
    task automatic model_commit(int k, bit rw, bit di, bit [1:0] cs, bit [7:0] d);
        for (int c = 0; c < 2; c++) begin
            if (!cs[c]) continue;
            if (rw && !(RB && di && (cs == 2'b01 || cs == 2'b10))) continue;
            if (m_rstn_low) continue;
            if (k - m_last[c] <= BC) begin m_err = 1; continue; end
            m_last[c] = k;
            if (!rw && !di) begin
                if (d[7:1] == 7'b0011111)  m_on[c] = d[0];
                else if (d[7:6] == 2'b11)  m_start[c] = int'(d[5:0]);
                else if (d[7:3] == 5'b10111) m_page[c] = int'(d[2:0]);
                else if (d[7:6] == 2'b01)  m_y[c] = int'(d[5:0]);
            end else if (!rw) begin
                m_mem[c][m_page[c]][m_y[c]] = d;
                m_known[c][m_page[c]][m_y[c]] = 1;
                m_y[c] = (m_y[c] + 1) % 64;
            end else begin
                m_lat[c] = m_mem[c][m_page[c]][m_y[c]];
                m_y[c] = (m_y[c] + 1) % 64;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge. dout/oe sampled at the last
    // negedge with ENABLE high (synchronized enable is high there when hi >= 2).
    task automatic xfer(bit rw, bit di, bit [1:0] cs, bit [7:0] d, int hi, int lo,
                        output logic [7:0] dout, output logic oe);
        LCD_RW = rw; LCD_DI = di; LCD_CS1 = cs[0]; LCD_CS2 = cs[1];
        LCD_DATA_IN = d; LCD_ENABLE = 1'b1;
        repeat (hi) @(negedge CLK);
        dout = LCD_DATA_OUT; oe = LCD_DATA_OE;
        LCD_ENABLE = 1'b0;
        model_commit(cyc + 3, rw, di, cs, d);
        repeat (lo) @(negedge CLK);
    endtask

    task automatic mir(string tag, bit c, int p, int col, logic [7:0] exp);
        RD_CHIP = c; RD_PAGE = 3'(p); RD_COL = 6'(col);
        @(negedge CLK);
        chk(tag, RD_DATA, exp);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".data_out"}, LCD_DATA_OUT, 0);
        chk({tag, ".data_oe"},  LCD_DATA_OE, 0);
        chk({tag, ".rd_data"},  RD_DATA, 0);
        chk({tag, ".on"},       DISPLAY_ON, 0);
        chk({tag, ".sl0"},      START_LINE0, 0);
        chk({tag, ".sl1"},      START_LINE1, 0);
        chk({tag, ".busy"},     BUSY, 0);
        chk({tag, ".err"},      ERR_OVERRUN, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (5) @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] dout;
        logic       oe;
        bit   [7:0] d;
        bit   [1:0] cs;
        bit         rw, di;
        int         hi, lo, kind;

        m_rstn_low = 0;
        model_reset();

        // reset state
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        // instruction writes on chip 0 only
        xfer(0, 0, 2'b01, 8'h3F, 2, 8, dout, oe);
        xfer(0, 0, 2'b01, 8'hC5, 2, 8, dout, oe);
        chk("t1.on",  DISPLAY_ON, 2'b01);
        chk("t1.sl0", START_LINE0, 5);
        chk("t1.sl1", START_LINE1, 0);

        // page 3, column 0 on chip 1, two data bytes
        xfer(0, 0, 2'b10, 8'hBB, 2, 8, dout, oe);
        xfer(0, 0, 2'b10, 8'h40, 2, 8, dout, oe);
        xfer(0, 1, 2'b10, 8'hAA, 2, 8, dout, oe);
        xfer(0, 1, 2'b10, 8'h55, 2, 8, dout, oe);
        mir("t2.c1p3y0", 1, 3, 0, 8'hAA);
        mir("t2.c1p3y1", 1, 3, 1, 8'h55);

        // column wrap from 63 to 0 on the same page
        xfer(0, 0, 2'b10, 8'h7F, 2, 8, dout, oe);
        xfer(0, 1, 2'b10, 8'h11, 2, 8, dout, oe);
        xfer(0, 1, 2'b10, 8'h22, 2, 8, dout, oe);
        mir("t3.c1p3y63", 1, 3, 63, 8'h11);
        mir("t3.c1p3y0",  1, 3, 0,  8'h22);

        // busy window: high for exactly BC cycles beginning 3 clocks after fall
        xfer(0, 0, 2'b01, 8'hB8, 2, 0, dout, oe);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            chk($sformatf("t4.busy%0d", i), BUSY[0], (i >= 3 && i < 3 + BC) ? 1 : 0);
        end

        // overrun: second commit inside the busy window is dropped
        xfer(0, 0, 2'b01, 8'h41, 2, 8, dout, oe);
        xfer(0, 1, 2'b01, 8'h99, 2, 8, dout, oe);
        xfer(0, 0, 2'b01, 8'h40, 2, 8, dout, oe);
        chk("t4.err_before", ERR_OVERRUN, 0);
        xfer(0, 1, 2'b01, 8'h77, 1, 2, dout, oe);
        xfer(0, 1, 2'b01, 8'h88, 1, 8, dout, oe);
        chk("t4.err", ERR_OVERRUN, 1);
        mir("t4.c0p0y0", 0, 0, 0, 8'h77);
        mir("t4.c0p0y1", 0, 0, 1, 8'h99);

        // reads
        do_reset();
`ifdef LCD_READBACK_EN
        xfer(0, 0, 2'b01, 8'hBA, 2, 8, dout, oe);
        xfer(0, 0, 2'b01, 8'h45, 2, 8, dout, oe);
        xfer(0, 1, 2'b01, 8'h3C, 2, 8, dout, oe);
        xfer(0, 0, 2'b01, 8'h45, 2, 8, dout, oe);
        xfer(1, 1, 2'b01, 8'h00, 3, 8, dout, oe);
        chk("t5.rd1_oe", oe, 1);
        chk("t5.rd1",    dout, 8'h00);
        xfer(1, 1, 2'b01, 8'h00, 3, 8, dout, oe);
        chk("t5.rd2",    dout, 8'h3C);
        xfer(0, 1, 2'b01, 8'hE1, 2, 8, dout, oe);
        mir("t5.y_plus2", 0, 2, 7, 8'hE1);
        xfer(1, 0, 2'b01, 8'h00, 3, 4, dout, oe);
        chk("t5.status", dout, 8'h20);
        chk("t5.status_nobusy", BUSY, 0);
        xfer(1, 1, 2'b11, 8'h00, 3, 8, dout, oe);
        chk("t5.both_oe",   oe, 0);
        chk("t5.both_data", dout, 8'h00);
`else
        xfer(1, 1, 2'b01, 8'h00, 3, 4, dout, oe);
        chk("t5.rd_oe",   oe, 0);
        chk("t5.rd_data", dout, 8'h00);
        chk("t5.rd_nobusy", BUSY, 0);
        repeat (4) @(negedge CLK);
`endif

        // panel reset: commits dropped without overrun
        LCD_RSTN = 1'b0;
        repeat (4) @(negedge CLK);
        m_rstn_low = 1; model_panel_clear();
`ifdef LCD_READBACK_EN
        xfer(1, 0, 2'b01, 8'h00, 3, 8, dout, oe);
        chk("t6.status_rst", dout, 8'h30);
`endif
        xfer(0, 0, 2'b01, 8'h3F, 2, 8, dout, oe);
        xfer(0, 1, 2'b01, 8'h5A, 2, 8, dout, oe);
        chk("t6.on",   DISPLAY_ON, 0);
        chk("t6.err",  ERR_OVERRUN, 0);
        chk("t6.busy", BUSY, 0);
        mir("t6.ram_kept", 0, 0, 0, 8'h77);
        LCD_RSTN = 1'b1;
        repeat (4) @(negedge CLK);
        m_rstn_low = 0;

        // RESET in the middle of a strobe aborts it
        LCD_RW = 0; LCD_DI = 0; LCD_CS1 = 1; LCD_CS2 = 0; LCD_DATA_IN = 8'h3F;
        LCD_ENABLE = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk_all_zero("t6.reset");
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        LCD_ENABLE = 1'b0;
        repeat (8) @(negedge CLK);
        chk("t6.abort_on",  DISPLAY_ON, 0);
        chk("t6.abort_err", ERR_OVERRUN, 0);
        mir("t6.ram_retained", 1, 3, 63, 8'h11);
        xfer(0, 0, 2'b01, 8'h3F, 2, 8, dout, oe);
        chk("t6.after_on", DISPLAY_ON, 2'b01);

        // randomized sequence against the model
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            cs   = 2'($urandom_range(0, 3));
            rw = 0; di = 0;
            case (kind)
                0: d = {7'b0011111, 1'($urandom)};
                1: d = {2'b11, 6'($urandom)};
                2: d = {5'b10111, 3'($urandom)};
                3: d = {2'b01, 6'($urandom)};
                4: d = 8'($urandom);
                9: begin rw = 1; di = 1'($urandom); d = 8'($urandom); end
                default: begin di = 1; d = 8'($urandom); end
            endcase
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 6);
            if (hi + lo < 4) lo = 4 - hi;
            xfer(rw, di, cs, d, hi, lo, dout, oe);
        end
        repeat (10) @(negedge CLK);
        chk("rnd.on",  DISPLAY_ON, {m_on[1], m_on[0]});
        chk("rnd.sl0", START_LINE0, m_start[0]);
        chk("rnd.sl1", START_LINE1, m_start[1]);
        chk("rnd.err", ERR_OVERRUN, m_err);
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 8; p++)
                for (int col = 0; col < 64; col++)
                    if (m_known[c][p][col])
                        mir($sformatf("rnd.ram c%0d p%0d y%0d", c, p, col),
                            1'(c), p, col, m_mem[c][p][col]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
